spi_pkg_reader: RTL and testbench
=================================

// Module: spi_pkg_reader
// PURPOSE
//  SPI master that drains one image package per interrupt from the DAQ FPGA's SPI slave port.
//  - Waits for intr_in, then asserts cs_n.
//  - Clocks PKT_BYTES bytes out of miso, then releases cs_n.
//  - Streams the bytes out on rx_data/rx_valid.
//  Sits on the host/bridge side of the intr/cs_n/sck/miso link; also serves as the bench-side model of the host.
// PARAMETERS
//  SCK_DIV    4    sys_clk cycles per sck half-period (>=2); sck = sys_clk/(2*SCK_DIV)
//  PKT_BYTES  600  bytes per package (one cs_n low window)
//  CS_SETUP   100  sys_clk cycles from cs_n fall to the first sck rise-phase start
//  CS_HOLD    100  sys_clk cycles cs_n stays high before intr_in is re-examined
//  CNT_W      16   width of byte and package counters
// PORTS
//  sys_clk    in   1      system clock, 50 MHz
//  sys_rst    in   1      synchronous reset, active-high
//  en         in   1      permits starting a new package; does not abort one in flight
//  intr_in    in   1      package-ready interrupt from DAQ, asynchronous
//  miso       in   1      serial data from slave, asynchronous to sys_clk
//  cs_n       out  1      chip select, active-low
//  sck        out  1      SPI clock, idle low (mode 0)
//  rx_data    out  8      received byte, MSB first
//  rx_valid   out  1      1-cycle strobe, rx_data valid
//  pkt_done   out  1      1-cycle strobe, package complete
//  busy       out  1      high in any state other than IDLE
//  pkt_cnt    out  CNT_W  completed packages, wraps at 2^CNT_W
//  pkt_sum    out  8      package checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset (sys_rst sampled high):
//   cs_n=1, sck=0, rx_data=0, rx_valid=0, pkt_done=0, busy=0, pkt_cnt=0, pkt_sum=0.
//   State=IDLE; all counters and the shift register clear on the next edge.
//   A mid-package reset aborts immediately; no pkt_done is issued.
//  Synchronisation: intr_in and miso each pass through 2-flop synchronisers.
//   intr_s is the synchronised interrupt.
//  FSM IDLE -> SETUP -> SHIFT -> HOLD -> REARM -> IDLE:
//   IDLE:  cs_n=1. Go to SETUP when intr_s=1 and en=1.
//   SETUP: cs_n=0, sck=0. Count CS_SETUP cycles, then go to SHIFT.
//   SHIFT: sck low for SCK_DIV cycles, then high for SCK_DIV cycles, repeating.
//    - On each sck rise, sample synchronised miso into shift register LSB (shift left).
//    - On the 8th rise of a byte, drive rx_data and pulse rx_valid on the next cycle.
//    - byte_cnt increments at that same point.
//    - After the falling edge that ends byte PKT_BYTES-1, go to HOLD.
//   HOLD:  cs_n=1, sck=0. pkt_done pulses and pkt_cnt++ on HOLD entry. Count CS_HOLD cycles.
//   REARM: wait for intr_s=0, then go to IDLE.
//    - Prevents re-reading the same package, since the slave holds intr high ~100 cycles after cs_n rises.
//  Timing:
//   - cs_n low time = CS_SETUP + 16*SCK_DIV*PKT_BYTES cycles.
//   - No sck edge occurs while cs_n=1.
//   - sck is always a registered output.
//  Boundaries:
//   - en falling mid-package: the package completes normally.
//   - intr_s falling mid-package: ignored.
//   - pkt_cnt wraps 2^CNT_W-1 -> 0.
//   - byte_cnt clears on SETUP entry.
// CONFIGURATION
//  PKT_SUM_EN defined:
//   - pkt_sum = 8-bit modulo sum of all bytes in the package.
//   - Accumulates on each rx_valid and clears on SETUP entry.
//   - Final value is valid from the pkt_done cycle until the next SETUP.
//  PKT_SUM_EN undefined: pkt_sum is tied to 0 and no accumulator is built.
// STRUCTURE
//  Package spi_pkg_reader_pkg:
//   - State encoding (one-hot localparams IDLE/SETUP/SHIFT/HOLD/REARM).
//   - SPI mode constants CPOL=0, CPHA=0.
//   - Widths for the half-period, delay and bit counters.
//  Sub-module sync_2ff: parameterised-width 2-flop synchroniser, instantiated for intr_in and miso.
//  FSM, sck generator and shift register live in the top module.
// TESTING
//  1. Reset mid-SHIFT (byte 10):
//     - Next cycle: cs_n=1, sck=0, busy=0.
//     - No pkt_done is issued.
//     - After release with intr=1, the reader restarts at byte 0.
//  2. Slave model returns bytes 0x00..0xFF repeating, SCK_DIV=4, PKT_BYTES=600, intr pulsed:
//     - 600 rx_valid strobes with matching data.
//     - Exactly one pkt_done, pkt_cnt=1.
//     - cs_n low for 100+38400 cycles.
//  3. intr held high across HOLD, then dropped, then raised again:
//     - Exactly 2 packages; REARM blocks the re-read.
//  4. en=0 with intr=1: cs_n stays 1 for 1000 cycles.
//     - en dropped at byte 300 of a package: all 600 bytes still arrive.
//  5. PKT_SUM_EN defined, package of 600 x 0x01: pkt_sum=0x58 at pkt_done.
//     - PKT_SUM_EN undefined: pkt_sum=0.
//  6. pkt_cnt preloaded to 0xFFFF by force, one package read: pkt_cnt=0x0000.
//     - Per-byte check: rx_valid occurs 1 cycle after the 8th sck rise.

Source files
------------

// File: rtl/spi_pkg_reader_pkg.sv
// Shared definitions for the SPI package reader: FSM state encoding,
// SPI mode constants, internal counter widths and the checksum helper.
package spi_pkg_reader_pkg;

    // One-hot reader states
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        SETUP = 5'b00010,
        SHIFT = 5'b00100,
        HOLD  = 5'b01000,
        REARM = 5'b10000
    } state_t;

    // SPI mode 0: sck idles low, data sampled on the leading (rising) edge
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // sck level right after the sampling edge
    localparam logic SAMPLE_LVL = ~(CPOL ^ CPHA);

    // Internal counter widths
    localparam int HALF_W = 8;   // sck half-period counter
    localparam int DLY_W  = 16;  // cs_n setup / hold delay counter
    localparam int BIT_W  = 3;   // bit-within-byte counter

    // Modulo-256 checksum step
    function automatic logic [7:0] sum8_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/spi_pkg_reader_sync_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage resynchronisation into the sys_clk domain
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spi_pkg_reader.sv
// SPI master (mode 0) that drains one fixed-size package from the DAQ slave
// each time the interrupt is raised, streaming the received bytes out.
// Optional feature macro: PKT_SUM_EN (8-bit modulo package checksum on pkt_sum).
module spi_pkg_reader #(
    parameter int SCK_DIV   = 4,
    parameter int PKT_BYTES = 600,
    parameter int CS_SETUP  = 100,
    parameter int CS_HOLD   = 100,
    parameter int CNT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             intr_in,
    input  logic             miso,
    output logic             cs_n,
    output logic             sck,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             pkt_done,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [7:0]       pkt_sum
);

    import spi_pkg_reader_pkg::*;

    state_t             state_r;
    state_t             state_nx_s;
    logic               intr_s;
    logic               miso_s;
    logic [DLY_W-1:0]   delay_r;
    logic [HALF_W-1:0]  half_r;
    logic [BIT_W-1:0]   bit_r;
    logic [CNT_W-1:0]   byte_r;
    logic [7:0]         shift_r;
    logic               byte_done_r;
    logic [7:0]         rx_data_r;
    logic               rx_valid_r;
    logic               pkt_done_r;
    logic               busy_r;
    logic               cs_n_r;
    logic               sck_r;
    logic [CNT_W-1:0]   pkt_cnt_r;

    logic half_end_s;
    logic rise_s;
    logic fall_s;
    logic last_byte_s;
    logic setup_done_s;
    logic hold_done_s;
    logic setup_entry_s;
    logic hold_entry_s;

    sync_2ff #(.W(1)) u_sync_intr (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d       (intr_in),
        .q       (intr_s)
    );

    sync_2ff #(.W(1)) u_sync_miso (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d       (miso),
        .q       (miso_s)
    );

    assign half_end_s    = (half_r == HALF_W'(SCK_DIV - 1));
    assign rise_s        = (state_r == SHIFT) && half_end_s && (sck_r != SAMPLE_LVL);
    assign fall_s        = (state_r == SHIFT) && half_end_s && (sck_r == SAMPLE_LVL);
    // byte_r counts a byte one cycle after its 8th rise, so it already equals
    // PKT_BYTES by the falling edge that closes the final byte
    assign last_byte_s   = (byte_r == CNT_W'(PKT_BYTES));
    assign setup_done_s  = (delay_r == DLY_W'(CS_SETUP - 1));
    assign hold_done_s   = (delay_r == DLY_W'(CS_HOLD - 1));
    assign setup_entry_s = (state_r == IDLE) && (state_nx_s == SETUP);
    assign hold_entry_s  = (state_r == SHIFT) && (state_nx_s == HOLD);

    // Next-state logic for the package read sequence
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (intr_s && en) state_nx_s = SETUP;
                else              state_nx_s = IDLE;
            end
            SETUP: begin
                if (setup_done_s) state_nx_s = SHIFT;
                else              state_nx_s = SETUP;
            end
            SHIFT: begin
                if (fall_s && last_byte_s) state_nx_s = HOLD;
                else                       state_nx_s = SHIFT;
            end
            HOLD: begin
                if (hold_done_s) state_nx_s = REARM;
                else             state_nx_s = HOLD;
            end
            REARM: begin
                // slave keeps intr high for a while after cs_n rises; wait it out
                if (!intr_s) state_nx_s = IDLE;
                else         state_nx_s = REARM;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register, delay counter, sck generator, shift register and output strobes
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r     <= IDLE;
            delay_r     <= {DLY_W{1'b0}};
            half_r      <= {HALF_W{1'b0}};
            bit_r       <= {BIT_W{1'b0}};
            byte_r      <= {CNT_W{1'b0}};
            shift_r     <= 8'd0;
            byte_done_r <= 1'b0;
            rx_data_r   <= 8'd0;
            rx_valid_r  <= 1'b0;
            pkt_done_r  <= 1'b0;
            busy_r      <= 1'b0;
            cs_n_r      <= 1'b1;
            sck_r       <= CPOL;
            pkt_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;

            if (state_nx_s != state_r) begin
                delay_r <= {DLY_W{1'b0}};
            end else if ((state_r == SETUP) || (state_r == HOLD)) begin
                delay_r <= delay_r + DLY_W'(1);
            end

            // sck toggles only while staying in SHIFT, so no edge escapes with cs_n high
            if ((state_r == SHIFT) && (state_nx_s == SHIFT)) begin
                if (half_end_s) begin
                    half_r <= {HALF_W{1'b0}};
                    sck_r  <= ~sck_r;
                end else begin
                    half_r <= half_r + HALF_W'(1);
                end
            end else begin
                half_r <= {HALF_W{1'b0}};
                sck_r  <= CPOL;
            end

            if (setup_entry_s) begin
                bit_r  <= {BIT_W{1'b0}};
                byte_r <= {CNT_W{1'b0}};
            end else begin
                if (rise_s) begin
                    shift_r <= {shift_r[6:0], miso_s};
                    bit_r   <= bit_r + BIT_W'(1);
                end
                if (byte_done_r) begin
                    byte_r <= byte_r + CNT_W'(1);
                end
            end

            byte_done_r <= rise_s && (bit_r == BIT_W'(7));
            rx_valid_r  <= byte_done_r;
            if (byte_done_r) begin
                rx_data_r <= shift_r;
            end

            pkt_done_r <= hold_entry_s;
            if (hold_entry_s) begin
                pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
            end

            cs_n_r <= !((state_nx_s == SETUP) || (state_nx_s == SHIFT));
            busy_r <= (state_nx_s != IDLE);
        end
    end

`ifdef PKT_SUM_EN
    logic [7:0] sum_r;

    // Running checksum of the current package; holds its final value until the next SETUP
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sum_r <= 8'd0;
        end else if (setup_entry_s) begin
            sum_r <= 8'd0;
        end else if (byte_done_r) begin
            sum_r <= sum8_add(sum_r, shift_r);
        end
    end

    assign pkt_sum = sum_r;
`else
    assign pkt_sum = 8'd0;
`endif

    assign cs_n     = cs_n_r;
    assign sck      = sck_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign pkt_done = pkt_done_r;
    assign busy     = busy_r;
    assign pkt_cnt  = pkt_cnt_r;

endmodule

// File: tb/tb_spi_pkg_reader.sv
// Self-checking bench for spi_pkg_reader: a mode-0 slave model feeds miso,
// expected bytes go to a scoreboard queue as the slave shifts them out and
// are compared when rx_valid fires. Package-level scenarios are table-driven.
module tb_spi_pkg_reader;

    localparam int SCK_DIV   = 4;
    localparam int PKT_BYTES = 16;
    localparam int CS_SETUP  = 10;
    localparam int CS_HOLD   = 12;
    localparam int CNT_W     = 16;
    localparam int CS_LOW    = CS_SETUP + 16 * SCK_DIV * PKT_BYTES;
    localparam int WIN       = 1200;
`ifdef PKT_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             en;
    logic             intr_in;
    logic             miso;
    logic             cs_n;
    logic             sck;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             pkt_done;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;
    logic [7:0]       pkt_sum;

    spi_pkg_reader #(
        .SCK_DIV   (SCK_DIV),
        .PKT_BYTES (PKT_BYTES),
        .CS_SETUP  (CS_SETUP),
        .CS_HOLD   (CS_HOLD),
        .CNT_W     (CNT_W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (en),
        .intr_in  (intr_in),
        .miso     (miso),
        .cs_n     (cs_n),
        .sck      (sck),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .pkt_done (pkt_done),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt),
        .pkt_sum  (pkt_sum)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // slave model and monitor state
    int         slv_mode = 0;
    logic [2:0] slv_bit  = 3'd0;
    int         slv_byte = 0;
    logic [7:0] slv_cur  = 8'd0;
    logic [7:0] sb_q[$];
    logic       sck_prev = 1'b0;
    logic       cs_prev  = 1'b1;
    int cyc = 0, last_rise = 0, low_run = 0, last_low = 0;
    int n_valid = 0, n_done = 0, n_cs_low = 0, pkt_bytes = 0;
    logic [7:0] last_sum  = 8'd0;
    logic [7:0] pkt_first = 8'hAA;
    logic [CNT_W-1:0] exp_cnt = '0;

    function automatic logic [7:0] pat(input int idx);
        if (slv_mode == 1) return 8'h01;
        else return 8'(idx);
    endfunction

    assign miso = slv_cur[3'd7 - slv_bit];

    // Slave shifting, scoreboard push/pop and per-cycle monitoring
    always @(negedge sys_clk) begin
        logic [7:0] exp_b;
        cyc++;
        if (sck && !sck_prev) last_rise = cyc;
        if (cs_n) begin
            slv_bit  = 3'd0;
            slv_byte = 0;
            slv_cur  = pat(0);
        end else if (sck && !sck_prev) begin
            if (slv_bit == 3'd7) begin
                sb_q.push_back(slv_cur);
                slv_byte++;
                slv_cur = pat(slv_byte);
                slv_bit = 3'd0;
            end else begin
                slv_bit = slv_bit + 3'd1;
            end
        end
        sck_prev = sck;
        if (cs_n) begin
            check("sck_idle_cs_high", sck, 0);
            if (!cs_prev) last_low = low_run;
            low_run   = 0;
            pkt_bytes = 0;
        end else begin
            low_run++;
            n_cs_low++;
        end
        cs_prev = cs_n;
        if (rx_valid) begin
            n_valid++;
            if (pkt_bytes == 0) pkt_first = rx_data;
            pkt_bytes++;
            check("rx_valid_after_8th_rise", cyc - last_rise, 1);
            check("sb_nonempty", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                exp_b = sb_q.pop_front();
                check("rx_data", rx_data, exp_b);
            end
        end
        if (pkt_done) begin
            n_done++;
            last_sum = pkt_sum;
        end
    end

    typedef struct {
        bit         en_v;
        bit         hold_v;
        int         mode_v;
        int         pkts;
        int         bytes;
        logic [7:0] sum_v;
    } vec_t;

    vec_t tbl[5];

    task automatic run_scn(input vec_t v, input string tag);
        int b_v, b_d, b_c;
        en       = v.en_v;
        slv_mode = v.mode_v;
        tick(10);
        b_v = n_valid; b_d = n_done; b_c = n_cs_low;
        intr_in = 1'b1;
        if (v.hold_v) begin
            tick(WIN);
        end else begin
            tick(8);
            intr_in = 1'b0;
            tick(WIN - 8);
        end
        intr_in = 1'b0;
        tick(10);
        exp_cnt = exp_cnt + CNT_W'(v.pkts);
        check({tag, "_bytes"}, n_valid - b_v, v.bytes);
        check({tag, "_pkt_done"}, n_done - b_d, v.pkts);
        check({tag, "_cs_low_cycles"}, n_cs_low - b_c, v.pkts * CS_LOW);
        check({tag, "_pkt_cnt"}, pkt_cnt, exp_cnt);
        check({tag, "_busy_idle"}, busy, 0);
        if (v.pkts > 0) begin
            check({tag, "_cs_low_window"}, last_low, CS_LOW);
            check({tag, "_pkt_sum"}, last_sum, SUM_ON ? v.sum_v : 8'h00);
        end
    endtask

    initial begin
        int b_v, b_d;
        sys_rst = 1'b1; en = 1'b0; intr_in = 1'b0;
        // sums: 0+1+..+15 = 120 = 0x78; 16 x 0x01 = 0x10
        tbl[0] = '{1'b1, 1'b0, 0, 1, PKT_BYTES, 8'h78};  // pulse, ramp data
        tbl[1] = '{1'b1, 1'b0, 1, 1, PKT_BYTES, 8'h10};  // pulse, all 0x01
        tbl[2] = '{1'b0, 1'b1, 0, 0, 0,         8'h00};  // en low: nothing starts
        tbl[3] = '{1'b1, 1'b1, 0, 1, PKT_BYTES, 8'h78};  // intr held: REARM blocks re-read
        tbl[4] = '{1'b1, 1'b0, 0, 1, PKT_BYTES, 8'h78};  // raised again: second package
        tick(3);
        check("rst_cs_n", cs_n, 1);
        check("rst_sck", sck, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_pkt_sum", pkt_sum, 0);
        sys_rst = 1'b0;

        for (int i = 0; i < 5; i++) run_scn(tbl[i], $sformatf("vec%0d", i));

        // en dropped halfway through a package: it still completes
        en = 1'b1; slv_mode = 0;
        tick(10);
        b_v = n_valid; b_d = n_done;
        intr_in = 1'b1; tick(8); intr_in = 1'b0;
        for (int i = 0; i < WIN && (n_valid - b_v) < PKT_BYTES / 2; i++) tick(1);
        check("en_drop_reached_mid", n_valid - b_v, PKT_BYTES / 2);
        en = 1'b0;
        tick(WIN);
        exp_cnt = exp_cnt + CNT_W'(1);
        check("en_drop_bytes", n_valid - b_v, PKT_BYTES);
        check("en_drop_pkt_done", n_done - b_d, 1);
        check("en_drop_pkt_cnt", pkt_cnt, exp_cnt);
        en = 1'b1;

        // reset during byte 10, intr kept high so the reader restarts
        tick(10);
        b_v = n_valid; b_d = n_done;
        intr_in = 1'b1;
        for (int i = 0; i < WIN && (n_valid - b_v) < 10; i++) tick(1);
        check("rst_mid_reached_byte10", n_valid - b_v, 10);
        sys_rst = 1'b1;
        tick(1);
        check("rst_mid_cs_n", cs_n, 1);
        check("rst_mid_sck", sck, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pkt_done", pkt_done, 0);
        check("rst_mid_pkt_cnt", pkt_cnt, 0);
        sys_rst = 1'b0;
        exp_cnt = '0;
        tick(5);
        check("rst_mid_no_done", n_done - b_d, 0);
        b_v = n_valid;
        tick(200);
        intr_in = 1'b0;  // falling mid-package is ignored
        tick(WIN);
        exp_cnt = exp_cnt + CNT_W'(1);
        check("rst_restart_bytes", n_valid - b_v, PKT_BYTES);
        check("rst_restart_first_byte", pkt_first, 8'h00);
        check("rst_restart_pkt_done", n_done - b_d, 1);
        check("rst_restart_pkt_cnt", pkt_cnt, exp_cnt);
        check("rst_restart_cs_low", last_low, CS_LOW);

        // package counter wrap
        force dut.pkt_cnt_r = 16'hFFFF;
        tick(1);
        release dut.pkt_cnt_r;
        exp_cnt = 16'hFFFF;
        run_scn(tbl[0], "wrap");
        check("wrap_pkt_cnt_zero", pkt_cnt, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
